plheader_stream: RTL and testbench



---
 rtl/plheader_pkg.sv | 51 +++++
 rtl/plheader_stream_if.sv | 25 ++
 rtl/plheader_pls_enc.sv | 13 +
 rtl/plheader_stream.sv | 108 ++++++++++
 tb/tb_plheader_stream.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/plheader_pkg.sv
// Shared constants, state type and the PLS encoder for the DVB-S2 PL header.
// The encoder function is also used by the receive-side header correlator.
package plheader_pkg;

    localparam int HDR_LEN = 90;
    localparam int PLS_LEN = 64;

    localparam logic [25:0] SOF_BITS_DEF = 26'h18D2E82;
    localparam logic [63:0] SCR_BITS_DEF = 64'h719D83C953422DFA;

    // Row i is gated by PLS bit b_i; row bit 31 is code bit y0.
    localparam logic [5:0][31:0] RM_ROWS = {
        32'hFFFFFFFF,
        32'h0000FFFF,
        32'h00FF00FF,
        32'h0F0F0F0F,
        32'h33333333,
        32'h55555555
    };

    localparam logic [2:0] CODE_E0_DEF = 3'd0;
    localparam logic [2:0] CODE_E1_DEF = 3'd3;
    localparam logic [2:0] CODE_O0_DEF = 3'd6;
    localparam logic [2:0] CODE_O1_DEF = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ENC,
        ST_STREAM
    } state_t;

    // Returns the scrambled 64-bit PLS field, first transmitted bit in [63].
    function automatic logic [63:0] pls_encode(input logic [4:0]  modcod,
                                               input logic [1:0]  ftype,
                                               input logic [63:0] scr = SCR_BITS_DEF);
        logic [6:0]  b;
        logic [31:0] y;
        logic [63:0] z;
        b = {ftype[0], ftype[1], modcod[0], modcod[1], modcod[2], modcod[3], modcod[4]};
        y = '0;
        for (int i = 0; i < 6; i++) begin
            if (b[i]) y = y ^ RM_ROWS[i];
        end
        for (int k = 0; k < 32; k++) begin
            z[63 - 2*k] = y[31 - k];
            z[62 - 2*k] = y[31 - k] ^ b[6];
        end
        return z ^ scr;
    endfunction

endpackage

// File: rtl/plheader_stream_if.sv
// Request and symbol-stream handshakes between frame scheduler, header
// generator and symbol mux.
interface plheader_stream_if #(
    parameter int SYM_W = 3
);
    logic             req_valid;
    logic             req_ready;
    logic [4:0]       modcod;
    logic [1:0]       ftype;
    logic             out_valid;
    logic             out_ready;
    logic [SYM_W-1:0] out_sym;
    logic [6:0]       out_idx;
    logic             out_last;

    modport master (
        output req_valid, modcod, ftype, out_ready,
        input  req_ready, out_valid, out_sym, out_idx, out_last
    );

    modport slave (
        input  req_valid, modcod, ftype, out_ready,
        output req_ready, out_valid, out_sym, out_idx, out_last
    );
endinterface

// File: rtl/plheader_pls_enc.sv
// Combinational RM(32,6) biorthogonal encode with b6 repetition and PLS
// scrambling; output bit [63] is transmitted first.
module plheader_pls_enc
    import plheader_pkg::*;
#(
    parameter logic [63:0] SCR_BITS = SCR_BITS_DEF
) (
    input  logic [4:0]  modcod,
    input  logic [1:0]  ftype,
    output logic [63:0] pls
);
    assign pls = pls_encode(modcod, ftype, SCR_BITS);
endmodule

// File: rtl/plheader_stream.sv
// Run-time DVB-S2 PL-header generator: builds SOF + scrambled PLS code for any
// MODCOD/TYPE and streams the 90 pi/2-BPSK symbol codes over valid/ready.
module plheader_stream
    import plheader_pkg::*;
#(
    parameter int                 SYM_W    = 3,
    parameter int                 SOF_LEN  = 26,
    parameter logic [SOF_LEN-1:0] SOF_BITS = SOF_BITS_DEF,
    parameter logic [63:0]        SCR_BITS = SCR_BITS_DEF,
    parameter logic [SYM_W-1:0]   CODE_E0  = SYM_W'(CODE_E0_DEF),
    parameter logic [SYM_W-1:0]   CODE_E1  = SYM_W'(CODE_E1_DEF),
    parameter logic [SYM_W-1:0]   CODE_O0  = SYM_W'(CODE_O0_DEF),
    parameter logic [SYM_W-1:0]   CODE_O1  = SYM_W'(CODE_O1_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    plheader_stream_if.slave  s
);
    localparam logic [6:0] LAST_IDX = 7'(HDR_LEN - 1);

    generate
        if (SOF_LEN + PLS_LEN != HDR_LEN) begin : g_len_err
            $error("plheader_stream: SOF_LEN + 64 must equal 90");
        end
    endgenerate

    state_t             state_reg, state_next;
    logic [HDR_LEN-1:0] sr_reg;
    logic [6:0]         cnt_reg;
    logic [4:0]         modcod_reg;
    logic [1:0]         ftype_reg;
    logic [63:0]        pls;

    plheader_pls_enc #(
        .SCR_BITS (SCR_BITS)
    ) u_pls_enc (
        .modcod (modcod_reg),
        .ftype  (ftype_reg),
        .pls    (pls)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= ST_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (s.req_valid) state_next = ST_ENC;
            ST_ENC:    state_next = ST_STREAM;
            ST_STREAM: if (s.out_ready && cnt_reg == LAST_IDX) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Datapath: request latch, header load and per-handshake shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_reg     <= '0;
            cnt_reg    <= '0;
            modcod_reg <= '0;
            ftype_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    cnt_reg <= '0;
                    if (s.req_valid) begin
                        modcod_reg <= s.modcod;
                        ftype_reg  <= s.ftype;
                    end
                end
                ST_ENC: begin
                    sr_reg  <= {SOF_BITS, pls};
                    cnt_reg <= '0;
                end
                ST_STREAM: begin
                    if (s.out_ready) begin
                        sr_reg  <= {sr_reg[HDR_LEN-2:0], 1'b0};
                        cnt_reg <= (cnt_reg == LAST_IDX) ? 7'd0 : cnt_reg + 7'd1;
                    end
                end
                default: cnt_reg <= '0;
            endcase
        end
    end

    // Outputs decode registered state only, so out_ready never reaches them.
    always_comb begin
        s.req_ready = 1'b0;
        s.out_valid = 1'b0;
        s.out_sym   = '0;
        s.out_idx   = '0;
        s.out_last  = 1'b0;
        case (state_reg)
            ST_IDLE: s.req_ready = 1'b1;
            ST_STREAM: begin
                s.out_valid = 1'b1;
                s.out_idx   = cnt_reg;
                s.out_last  = (cnt_reg == LAST_IDX);
                if (cnt_reg[0]) s.out_sym = sr_reg[HDR_LEN-1] ? CODE_O1 : CODE_O0;
                else            s.out_sym = sr_reg[HDR_LEN-1] ? CODE_E1 : CODE_E0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_plheader_stream.sv
// Directed bench for plheader_stream with a scoreboard fed at request accept
// and drained at each symbol handshake.
module tb_plheader_stream;

    localparam logic [25:0] T_SOF = 26'h18D2E82;
    localparam logic [63:0] T_SCR = 64'h719D83C953422DFA;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    plheader_stream_if #(.SYM_W(3)) bus ();

    plheader_stream dut (
        .clk (clk),
        .rst (rst),
        .s   (bus)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          hs_cnt = 0;
    int          hdr_done = 0;
    int          acc_cyc = 0;
    int          last_hs_cyc = -1;
    bit          chk_gap = 1'b0;
    bit          prev_stall = 1'b0;
    bit          prev_valid = 1'b0;
    logic [10:0] prev_out = '0;
    logic [10:0] exp_q[$];
    logic [2:0]  cap[90];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // RM code bit k is the parity of b0..b4 against the bits of k, plus b5.
    function automatic logic [89:0] golden(input logic [4:0] mc, input logic [1:0] ft);
        logic [63:0] z;
        logic [4:0]  kv;
        logic        yk;
        for (int k = 0; k < 32; k++) begin
            kv = 5'(k);
            yk = (mc[4] & kv[0]) ^ (mc[3] & kv[1]) ^ (mc[2] & kv[2]) ^
                 (mc[1] & kv[3]) ^ (mc[0] & kv[4]) ^ ft[1];
            z[63 - 2*k] = yk;
            z[62 - 2*k] = yk ^ ft[0];
        end
        return {T_SOF, z ^ T_SCR};
    endfunction

    function automatic logic [2:0] sym_code(input logic b, input int idx);
        if (idx % 2 == 0) return b ? 3'd3 : 3'd0;
        else              return b ? 3'd5 : 3'd6;
    endfunction

    task automatic push_hdr(input logic [4:0] mc, input logic [1:0] ft);
        logic [89:0] g;
        g = golden(mc, ft);
        for (int i = 0; i < 90; i++)
            exp_q.push_back({(i == 89), 7'(i), sym_code(g[89 - i], i)});
    endtask

    // Observe this cycle's inputs/outputs (they hold through the next edge), then advance.
    task automatic tick();
        logic [10:0] cur;
        logic [10:0] e;
        cur = {bus.out_last, bus.out_idx, bus.out_sym};
        if (bus.out_valid) chk("req_ready_in_stream", 32'(bus.req_ready), 32'd0);
        if (prev_stall) begin
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_hold", 32'(cur), 32'(prev_out));
        end
        if (bus.out_valid && !prev_valid) begin
            chk("first_latency", 32'(cyc - acc_cyc), 32'd2);
            if (chk_gap && last_hs_cyc >= 0) chk("b2b_gap", 32'(cyc - last_hs_cyc), 32'd3);
        end
        if (bus.req_valid && bus.req_ready) begin
            push_hdr(bus.modcod, bus.ftype);
            acc_cyc = cyc;
        end
        if (bus.out_valid && bus.out_ready) begin
            chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sym", 32'(bus.out_sym), 32'(e[2:0]));
                chk("idx", 32'(bus.out_idx), 32'(e[9:3]));
                chk("last", 32'(bus.out_last), 32'(e[10]));
                if (int'(bus.out_idx) < 90) cap[bus.out_idx] = bus.out_sym;
                hs_cnt++;
                if (e[10]) begin
                    hdr_done++;
                    last_hs_cyc = cyc;
                    $display("header done #%0d at cycle %0d", hdr_done, cyc);
                end
            end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_valid = bus.out_valid;
        prev_out   = cur;
        @(negedge clk);
        cyc++;
    endtask

    task automatic request(input logic [4:0] mc, input logic [1:0] ft);
        int budget;
        budget = 300;
        while (!bus.req_ready && budget > 0) begin
            tick();
            budget--;
        end
        chk("req_ready_wait", 32'(bus.req_ready), 32'd1);
        bus.modcod    = mc;
        bus.ftype     = ft;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic run_until(input int n_hdr, input int low_pct, input bit mutate);
        int target;
        int budget;
        target = hdr_done + n_hdr;
        budget = n_hdr * 400;
        while (hdr_done < target && budget > 0) begin
            bus.out_ready = ($urandom_range(99) >= low_pct);
            if (mutate && bus.out_valid && bus.out_idx == 7'd45) begin
                bus.modcod = bus.modcod + 5'd7;
                bus.ftype  = bus.ftype + 2'd1;
            end
            tick();
            budget--;
        end
        chk("hdr_complete", 32'(hdr_done), 32'(target));
    endtask

    logic [2:0] sof_exp[8];
    logic [2:0] scr_exp[4];
    int         h0;
    int         budget;

    initial begin
        sof_exp = '{3'd0, 3'd5, 3'd3, 3'd6, 3'd0, 3'd6, 3'd3, 3'd5};
        scr_exp = '{3'd0, 3'd5, 3'd3, 3'd5};
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.modcod    = '0;
        bus.ftype     = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_sym", 32'(bus.out_sym), 32'd0);
        chk("rst_out_idx", 32'(bus.out_idx), 32'd0);
        chk("rst_out_last", 32'(bus.out_last), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        rst = 1'b0;
        tick();

        // Case 1: MODCOD 0, TYPE 0
        request(5'd0, 2'd0);
        run_until(1, 0, 1'b0);
        for (int i = 0; i < 8; i++) chk($sformatf("sof_sym%0d", i), 32'(cap[i]), 32'(sof_exp[i]));
        for (int i = 0; i < 4; i++) chk($sformatf("scr_sym%0d", 26 + i), 32'(cap[26 + i]), 32'(scr_exp[i]));

        // Case 2: MODCOD 1F / TYPE 3, then all 128 combinations
        request(5'h1F, 2'b11);
        run_until(1, 0, 1'b0);
        for (int m = 0; m < 128; m++) begin
            request(5'(m >> 2), 2'(m));
            run_until(1, 0, 1'b0);
        end

        // Case 3: 30% backpressure
        h0 = hs_cnt;
        request(5'd0, 2'd0);
        run_until(1, 30, 1'b0);
        chk("bp_handshakes", 32'(hs_cnt - h0), 32'd90);

        // Case 4: req_valid held high, modcod changes mid-stream
        bus.out_ready = 1'b1;
        tick();
        chk_gap       = 1'b1;
        last_hs_cyc   = -1;
        bus.modcod    = 5'h0A;
        bus.ftype     = 2'b01;
        bus.req_valid = 1'b1;
        run_until(3, 0, 1'b1);
        bus.req_valid = 1'b0;
        chk_gap       = 1'b0;
        tick();

        // Case 5: asynchronous reset at idx 40
        request(5'h13, 2'b10);
        budget = 200;
        bus.out_ready = 1'b1;
        while (!(bus.out_valid && bus.out_idx == 7'd40) && budget > 0) begin
            tick();
            budget--;
        end
        chk("reach_idx40", 32'(bus.out_idx), 32'd40);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("async_rst_idx", 32'(bus.out_idx), 32'd0);
        exp_q.delete();
        prev_stall = 1'b0;
        prev_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cap[0] = 3'd7;
        tick();
        request(5'd0, 2'd0);
        run_until(1, 0, 1'b0);
        chk("restart_sym0", 32'(cap[0]), 32'd0);

        tick();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
